rsa_core_arbiter: RTL and testbench

Shares one Rsa256Core between NREQ independent requesters, for example several UART/Avalon wrappers or a self-test engine. The block arbitrates round-robin and latches the winner's operands (a, d, n). It then pulses the core start, waits for finished, and returns the result to the owning requester over a valid/ready response channel. An optional watchdog aborts a hung computation and flags an error.

---
 rtl/rsa_core_arbiter_pkg.sv | 13 +
 rtl/rsa_core_arbiter_rr.sv | 26 ++
 rtl/rsa_core_arbiter.sv | 148 ++++++++++++++
 tb/tb_rsa_core_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_core_arbiter_pkg.sv
// Shared types and constants for the RSA core arbiter.
package rsa_arb_pkg;

  localparam int BW_DEFAULT = 256;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rsa_core_arbiter_rr.sv
// Combinational round-robin picker: one-hot grant of the first request after i_ptr.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_grant
);

  always_comb begin
    logic found;
    int   idx;
    found   = 1'b0;
    idx     = 0;
    o_grant = '0;
    // i_ptr is the last served requester, so the search starts one past it.
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(i_ptr) + i) % NREQ;
      if (!found && i_req[idx]) begin
        o_grant[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rsa_core_arbiter.sv
// Shares one RSA core among NREQ requesters: round-robin grant, operand latch,
// start/finish sequencing, owner-directed response and an optional watchdog.
module rsa_core_arbiter
  import rsa_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int BW          = BW_DEFAULT,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NREQ-1:0]    i_req_valid,
  output logic [NREQ-1:0]    o_req_ready,
  input  logic [NREQ*BW-1:0] i_req_a,
  input  logic [NREQ*BW-1:0] i_req_d,
  input  logic [NREQ*BW-1:0] i_req_n,
  output logic [NREQ-1:0]    o_rsp_valid,
  input  logic [NREQ-1:0]    i_rsp_ready,
  output logic [BW-1:0]      o_rsp_data,
  output logic               o_rsp_err,
  output logic               o_core_start,
  output logic [BW-1:0]      o_core_a,
  output logic [BW-1:0]      o_core_d,
  output logic [BW-1:0]      o_core_n,
  input  logic [BW-1:0]      i_core_result,
  input  logic               i_core_finished,
  output logic               o_busy,
  output logic [1:0]         o_dbg_state
);

  localparam int PW = $clog2(NREQ);
  localparam bit WDOG_EN = (TIMEOUT_CYC > 0);
  localparam int WW = WDOG_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [WW-1:0] WDOG_LAST = WDOG_EN ? WW'(TIMEOUT_CYC - 1) : '0;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [BW-1:0]   core_a_q, core_a_d;
  logic [BW-1:0]   core_d_q, core_d_d;
  logic [BW-1:0]   core_n_q, core_n_d;
  logic [BW-1:0]   rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [WW-1:0]   wdog_q, wdog_d;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   win;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .i_req   (i_req_valid),
    .i_ptr   (ptr_q),
    .o_grant (grant)
  );

  always_comb begin
    win = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) win = PW'(k);
    end
  end

  // Both channels use valid/ready: a transfer happens on the rising clock edge
  // where valid and ready are both high; the sender holds its payload until then.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    core_a_d     = core_a_q;
    core_d_d     = core_d_q;
    core_n_d     = core_n_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    wdog_d       = wdog_q;
    o_req_ready  = '0;
    o_rsp_valid  = '0;
    o_core_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_req_ready = grant;
        if (|grant) begin
          core_a_d = i_req_a[win*BW +: BW];
          core_d_d = i_req_d[win*BW +: BW];
          core_n_d = i_req_n[win*BW +: BW];
          owner_d  = win;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        o_core_start = 1'b1;
        wdog_d       = '0;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        if (WDOG_EN && wdog_q != '1) wdog_d = wdog_q + 1'b1;
        // A finish on the final watchdog cycle takes priority over the abort.
        if (i_core_finished) begin
          rsp_data_d = i_core_result;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (WDOG_EN && wdog_q == WDOG_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        o_rsp_valid[owner_q] = 1'b1;
        if (i_rsp_ready[owner_q]) begin
          ptr_d   = owner_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= PW'(NREQ - 1);
      owner_q    <= '0;
      core_a_q   <= '0;
      core_d_q   <= '0;
      core_n_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      core_a_q   <= core_a_d;
      core_d_q   <= core_d_d;
      core_n_q   <= core_n_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      wdog_q     <= wdog_d;
    end
  end

  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_core_a    = core_a_q;
  assign o_core_d    = core_d_q;
  assign o_core_n    = core_n_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_rsa_core_arbiter.sv
// Bench for rsa_core_arbiter: cycle-level reference model, core model and response scoreboard.
module tb_rsa_core_arbiter;

  localparam int NREQ = 4;
  localparam int BW   = 32;
  localparam int TO   = 16;
  localparam int RW   = 2 + 1 + BW;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*BW-1:0] req_a, req_d, req_n;
  logic [BW-1:0]     rsp_data, core_a, core_d, core_n, core_res;
  logic              rsp_err, core_start, core_fin, spur_fin, busy;
  logic [1:0]        dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  rsa_core_arbiter #(.NREQ(NREQ), .BW(BW), .TIMEOUT_CYC(TO)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_a         (req_a),
    .i_req_d         (req_d),
    .i_req_n         (req_n),
    .o_rsp_valid     (rsp_valid),
    .i_rsp_ready     (rsp_ready),
    .o_rsp_data      (rsp_data),
    .o_rsp_err       (rsp_err),
    .o_core_start    (core_start),
    .o_core_a        (core_a),
    .o_core_d        (core_d),
    .o_core_n        (core_n),
    .i_core_result   (core_res),
    .i_core_finished (core_fin | spur_fin),
    .o_busy          (busy),
    .o_dbg_state     (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [RW-1:0] exp_q[$];

  // reference model state
  bit              m_busy;
  int              m_ptr, m_owner, m_cyc, m_due;
  int              lat_k[NREQ];
  int              cur_lat;
  logic [NREQ-1:0] last_ready;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [BW-1:0] modexp(input logic [BW-1:0] a, input logic [BW-1:0] d,
                                           input logic [BW-1:0] n);
    longint unsigned r, b, e;
    r = 1;
    b = longint'(a) % longint'(n);
    e = longint'(d);
    while (e != 0) begin
      if (e[0]) r = (r * b) % longint'(n);
      b = (b * b) % longint'(n);
      e = e >> 1;
    end
    return BW'(r % longint'(n));
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int i = 1; i <= NREQ; i++) begin
      if (v[(last + i) % NREQ]) return (last + i) % NREQ;
    end
    return -1;
  endfunction

  // driver tasks
  task automatic set_req(input int k, input int a, input int d, input int n, input int lat);
    req_a[k*BW +: BW] = BW'(a);
    req_d[k*BW +: BW] = BW'(d);
    req_n[k*BW +: BW] = BW'(n);
    lat_k[k]     = lat;
    req_valid[k] = 1'b1;
  endtask

  // One clock cycle: compare the DUT against the model at the falling edge,
  // advance the model, then drop valid for any requester granted at the rising edge.
  task automatic step();
    logic [NREQ-1:0] exp_ready, exp_rv;
    int w, lt;
    bit tmo;
    logic [BW-1:0] e_data;
    @(negedge clk);
    if (m_busy) m_cyc++;
    exp_ready = '0;
    w = -1;
    if (!m_busy) begin
      w = rr_pick(req_valid, m_ptr);
      if (w >= 0) exp_ready[w] = 1'b1;
    end
    exp_rv = (m_busy && m_cyc >= m_due) ? (NREQ'(1) << m_owner) : '0;
    check("req_ready", req_ready, exp_ready);
    check("rsp_valid", rsp_valid, exp_rv);
    check("core_start", core_start, m_busy && m_cyc == 1);
    check("busy", busy, m_busy);
    last_ready = req_ready;
    if (w >= 0) begin
      lt     = lat_k[w];
      tmo    = (lt == 0) || (lt > TO);
      e_data = tmo ? '0 : modexp(req_a[w*BW +: BW], req_d[w*BW +: BW], req_n[w*BW +: BW]);
      exp_q.push_back({2'(w), tmo, e_data});
      m_busy  = 1'b1;
      m_owner = w;
      m_cyc   = 0;
      m_due   = 2 + (tmo ? TO : lt);
      cur_lat = lt;
    end else if (|(exp_rv & rsp_ready)) begin
      m_busy = 1'b0;
      m_ptr  = m_owner;
    end
    @(posedge clk);
    #1;
    req_valid &= ~exp_ready;
  endtask

  task automatic wait_rsp(input logic [NREQ-1:0] exp_mask);
    for (int c = 0; c < 40; c++) begin
      if (|rsp_valid) break;
      step();
    end
    check("rsp_seen", rsp_valid, exp_mask);
  endtask

  task automatic drain();
    rsp_ready = '1;
    spur_fin  = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (!m_busy && req_valid == '0) break;
      step();
    end
    step();
    check("drain_idle", dbg_state, 2'd0);
  endtask

  // core model: finishes lat cycles into S_WAIT; lat 0 never finishes; reset aborts
  int          core_lat_v;
  logic [BW-1:0] core_r_v;
  bit          core_abort;
  initial begin
    core_fin = 1'b0;
    core_res = '0;
    forever begin
      @(negedge clk);
      if (!rst && core_start) begin
        core_lat_v = cur_lat;
        core_r_v   = modexp(core_a, core_d, core_n);
        core_abort = 1'b0;
        if (core_lat_v > 0) begin
          for (int i = 0; i < core_lat_v && !core_abort; i++) begin
            @(negedge clk);
            if (rst) core_abort = 1'b1;
          end
          if (!core_abort) begin
            core_fin = 1'b1;
            core_res = core_r_v;
            @(negedge clk);
            core_fin = 1'b0;
            core_res = BW'($urandom);
          end
        end
      end
    end
  end

  // scoreboard monitor: every valid response cycle is compared against the queue head
  logic [RW-1:0] mon_e;
  always @(negedge clk) begin
    if (!rst && |rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", rsp_valid, '0);
      end else begin
        mon_e = exp_q[0];
        check("rsp_owner", rsp_valid, NREQ'(1) << mon_e[RW-1 -: 2]);
        check("rsp_data", rsp_data, mon_e[BW-1:0]);
        check("rsp_err", rsp_err, mon_e[BW]);
        if (|(rsp_valid & rsp_ready)) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  int j, raised;
  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_d = '0; req_n = '0;
    rsp_ready = '1; spur_fin = 1'b0;
    m_busy = 1'b0; m_ptr = NREQ - 1; m_owner = 0; m_cyc = 0; m_due = 0; cur_lat = 1;
    for (int k = 0; k < NREQ; k++) lat_k[k] = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_core_start", core_start, 1'b0);
    check("rst_core_a", core_a, '0);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_rsp_err", rsp_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // single request from requester 2
    set_req(2, 5, 3, 7, 10);
    wait_rsp(4'b0100);
    check("t1_data", rsp_data, 32'd6);
    check("t1_err", rsp_err, 1'b0);
    step();
    check("t1_idle", dbg_state, 2'd0);
    set_req(3, 4, 3, 9, 2);
    drain();

    // fairness with every requester continuously valid
    for (int k = 0; k < NREQ; k++) set_req(k, k + 2, 2, 11, 3 + k);
    raised = 4;
    j = 0;
    for (int c = 0; c < 400 && j < 8; c++) begin
      step();
      if (|last_ready) begin
        check("fair_order", last_ready, NREQ'(1) << (j % NREQ));
        j++;
      end
      for (int k = 0; k < NREQ; k++) begin
        if (!req_valid[k] && raised < 8) begin
          set_req(k, k + 2, 2, 11, 3 + k);
          raised++;
        end
      end
    end
    check("fair_count", 64'(j), 64'd8);
    drain();

    // response backpressure, non-owner ready, spurious finish in S_RESP
    rsp_ready = 4'b1110;
    set_req(0, 10, 5, 13, 4);
    set_req(1, 6, 2, 17, 3);
    wait_rsp(4'b0001);
    for (int c = 0; c < 20; c++) begin
      spur_fin = (c == 7);
      step();
    end
    spur_fin = 1'b0;
    check("bp_no_grant", req_ready, '0);
    rsp_ready = '1;
    step();
    check("bp_grant1", req_ready, 4'b0010);
    drain();

    // watchdog: hang, finish on the last cycle, finish after the abort
    set_req(2, 9, 3, 23, 0);
    wait_rsp(4'b0100);
    check("wd_err", rsp_err, 1'b1);
    check("wd_data", rsp_data, '0);
    drain();
    set_req(2, 3, 4, 13, 16);
    wait_rsp(4'b0100);
    check("wd_tie_err", rsp_err, 1'b0);
    check("wd_tie_data", rsp_data, 32'd3);
    drain();
    set_req(3, 7, 2, 19, 17);
    drain();

    // spurious finish in idle, withdrawn request
    spur_fin = 1'b1;
    step();
    spur_fin = 1'b0;
    check("spur_idle", dbg_state, 2'd0);
    set_req(1, 8, 3, 29, 8);
    step();
    set_req(3, 2, 5, 31, 2);
    repeat (3) step();
    req_valid[3] = 1'b0;
    drain();

    // reset during S_WAIT
    set_req(2, 4, 4, 37, 12);
    for (int c = 0; c < 20; c++) begin
      step();
      if (m_busy && m_cyc >= 4) break;
    end
    check("mid_state", dbg_state, 2'd2);
    #2;
    rst = 1'b1;
    #1;
    check("mid_busy", busy, 1'b0);
    check("mid_state0", dbg_state, 2'd0);
    check("mid_core_a", core_a, '0);
    check("mid_core_d", core_d, '0);
    check("mid_core_n", core_n, '0);
    check("mid_rsp_valid", rsp_valid, '0);
    check("mid_rsp_data", rsp_data, '0);
    m_busy = 1'b0;
    m_ptr  = NREQ - 1;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    set_req(3, 5, 2, 41, 3);
    set_req(0, 6, 2, 41, 3);
    step();
    check("rst_next_grant", last_ready, 4'b0001);
    drain();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!req_valid[k] && $urandom_range(0, 7) == 0)
          set_req(k, $urandom_range(0, 300), $urandom_range(0, 12), $urandom_range(2, 250),
                  $urandom_range(0, 17));
        else if (req_valid[k] && $urandom_range(0, 39) == 0)
          req_valid[k] = 1'b0;
      end
      rsp_ready = NREQ'($urandom_range(0, 15));
      spur_fin  = (!m_busy || (m_cyc + 1 >= m_due)) && ($urandom_range(0, 9) == 0);
      step();
    end
    req_valid = '0;
    drain();
    check("end_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
